// File: rtl/freq_gate_controller_if.sv
// ============================================================================
// freq_gate_controller_if
// ----------------------------------------------------------------------------
// Result hand-off bus between the frequency-counter gate controller and the
// display side (OLED renderer).
//
// Signals:
//   result_out          : latched BCD result, 4 bits per digit
//   result_overflow_out : latched overflow flag, valid alongside result_out
//   result_valid_out    : a new result is pending for the display side
//   result_overrun_out  : a pending result was overwritten before being acked
//   result_ack_in       : display side has consumed the pending result
//
// Modports:
//   master : controller side (drives the result, samples the ack)
//   slave  : display side (samples the result, drives the ack)
// ============================================================================
interface freq_gate_controller_if #(
    parameter int DIGITS_NUM = 6
);

    logic [4*DIGITS_NUM-1:0] result_out;
    logic                    result_overflow_out;
    logic                    result_valid_out;
    logic                    result_overrun_out;
    logic                    result_ack_in;

    modport master (
        output result_out,
        output result_overflow_out,
        output result_valid_out,
        output result_overrun_out,
        input  result_ack_in
    );

    modport slave (
        input  result_out,
        input  result_overflow_out,
        input  result_valid_out,
        input  result_overrun_out,
        output result_ack_in
    );

endinterface

// File: rtl/freq_gate_controller.sv
// ============================================================================
// freq_gate_controller
// ----------------------------------------------------------------------------
// Measurement sequencer for the frequency counter. The external signal is
// synchronised and edge-detected; each rising edge seen during the gate window
// becomes a one-cycle count pulse for the external N-digit BCD counter. At the
// end of the window the counter value and an overflow flag are latched into a
// holding register and handed to the display side through a valid/ack
// handshake, so the display never reads a counter that is still counting.
//
// Parameters:
//   DIGITS_NUM  : BCD digits of the attached counter and of the result
//   GATE_CYCLES : gate window length in clk_in cycles (must be >= 4)
//
// Ports:
//   clk_in             : system clock
//   reset_in           : asynchronous active-low reset
//   signal_in          : measured signal, asynchronous to clk_in
//   start_in           : single-shot request, honoured only while idle
//   continuous_in      : free-running measurement mode
//   counter_digits_in  : BCD value from the counter
//   counter_carry_in   : top-digit carry from the counter
//   counter_reset_out  : active-high reset to the counter
//   counter_enable_out : one-cycle count pulse per rising edge of signal_in
//   gate_out           : high for every gate cycle
//   busy_out           : high whenever a measurement is in progress
//   disp               : result hand-off bus (master side)
// ============================================================================
module freq_gate_controller #(
    parameter int DIGITS_NUM  = 6,
    parameter int GATE_CYCLES = 12_000_000
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    signal_in,
    input  logic                    start_in,
    input  logic                    continuous_in,
    input  logic [4*DIGITS_NUM-1:0] counter_digits_in,
    input  logic                    counter_carry_in,
    output logic                    counter_reset_out,
    output logic                    counter_enable_out,
    output logic                    gate_out,
    output logic                    busy_out,
    freq_gate_controller_if.master  disp
);

    // The gate counter only has to reach GATE_CYCLES-1, so $clog2 bits suffice
    // even when GATE_CYCLES is a power of two.
    localparam int              CNT_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   gate_count;
    logic               overflow_acc;
    logic               sync_q1;
    logic               sync_q2;
    logic               sync_q3;
    logic               rise;

    // Two flops resolve metastability; the third holds the previous
    // synchronised level so a rising edge shows up as a single-cycle pulse.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= signal_in;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~sync_q3;

    // Edges outside the gate window are simply dropped, never deferred.
    assign counter_enable_out = rise & (state == GATE);

    // Sequencer. The counter is held in reset while idle and during CLEAR so
    // every window starts from zero; the gate counter times the window and the
    // overflow accumulator remembers any carry-out seen while counting.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state             <= IDLE;
            gate_count        <= '0;
            overflow_acc      <= 1'b0;
            counter_reset_out <= 1'b1;
            gate_out          <= 1'b0;
            busy_out          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in | continuous_in) begin
                        state             <= CLEAR;
                        busy_out          <= 1'b1;
                        counter_reset_out <= 1'b1;
                    end
                end
                CLEAR: begin
                    gate_count        <= '0;
                    overflow_acc      <= 1'b0;
                    state             <= GATE;
                    gate_out          <= 1'b1;
                    counter_reset_out <= 1'b0;
                end
                GATE: begin
                    gate_count <= gate_count + CNT_W'(1);
                    if (counter_carry_in & counter_enable_out) begin
                        overflow_acc <= 1'b1;
                    end
                    if (gate_count == LAST_COUNT) begin
                        state    <= LATCH;
                        gate_out <= 1'b0;
                    end
                end
                LATCH: begin
                    counter_reset_out <= 1'b1;
                    if (continuous_in) begin
                        state <= CLEAR;
                    end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state             <= IDLE;
                    gate_out          <= 1'b0;
                    busy_out          <= 1'b0;
                    counter_reset_out <= 1'b1;
                end
            endcase
        end
    end

    // Holding register and handshake. A latch always overwrites the held
    // data; an ack arriving in the same cycle as a latch retires the old data,
    // so the new result stays valid and no overrun is flagged.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            disp.result_out          <= '0;
            disp.result_overflow_out <= 1'b0;
            disp.result_valid_out    <= 1'b0;
            disp.result_overrun_out  <= 1'b0;
        end else if (state == LATCH) begin
            disp.result_out          <= counter_digits_in;
            disp.result_overflow_out <= overflow_acc;
            disp.result_valid_out    <= 1'b1;
            disp.result_overrun_out  <= (disp.result_valid_out & ~disp.result_ack_in)
                                        | (disp.result_overrun_out & ~disp.result_ack_in);
        end else if (disp.result_ack_in) begin
            disp.result_valid_out   <= 1'b0;
            disp.result_overrun_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_gate_controller.sv
// ============================================================================
// tb_freq_gate_controller
// ----------------------------------------------------------------------------
// Bench for freq_gate_controller. Two instances share every control input:
// one with a 2-digit counter and one with a 1-digit counter (to reach the
// overflow path). Each instance drives a behavioural BCD counter. A reference
// model predicts, from the documented timing, which clock cycles form each
// gate window and how many signal rises fall inside it; predictions are
// queued and popped by monitors when the DUTs present a new result.
// ============================================================================
module tb_freq_gate_controller;

    localparam int G     = 20;
    localparam int DA    = 2;
    localparam int DB    = 1;
    localparam int MOD_A = 100;
    localparam int MOD_B = 10;

    typedef struct {
        logic [31:0] res;
        bit          ovf;
        int          edge_at;
    } item_t;

    logic clk           = 1'b0;
    logic reset_in      = 1'b1;
    logic signal_in     = 1'b0;
    logic start_in      = 1'b0;
    logic continuous_in = 1'b0;
    logic ack_in        = 1'b0;

    logic          cre_a, en_a, gate_a, busy_a;
    logic          cre_b, en_b, gate_b, busy_b;
    logic [4*DA-1:0] digits_a;
    logic [4*DB-1:0] digits_b;
    logic          carry_a, carry_b;
    logic [31:0]   bcd_a, bcd_b;
    int            cnt_a = 0;
    int            cnt_b = 0;

    int compared   = 0;
    int mismatched = 0;

    // stimulus control
    int sig_mode   = 0;
    bit sig_level  = 1'b0;
    int sig_period = 2;
    int sig_phase  = 0;
    bit rand_ctrl  = 1'b0;

    // reference model state
    int    edge_count = 0;
    bit    h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    bit    measuring = 1'b0;
    int    win_start = 0;
    int    pulses = 0;
    int    m_phase;
    bit    m_latch;
    bit    exp_valid = 1'b0, exp_overrun = 1'b0;
    bit    exp_busy = 1'b0, exp_gate = 1'b0, exp_creset = 1'b1;
    item_t q_a[$];
    item_t q_b[$];
    item_t m_item;

    freq_gate_controller_if #(.DIGITS_NUM(DA)) bus_a ();
    freq_gate_controller_if #(.DIGITS_NUM(DB)) bus_b ();

    assign bus_a.result_ack_in = ack_in;
    assign bus_b.result_ack_in = ack_in;

    freq_gate_controller #(.DIGITS_NUM(DA), .GATE_CYCLES(G)) dut_a (
        .clk_in             (clk),
        .reset_in           (reset_in),
        .signal_in          (signal_in),
        .start_in           (start_in),
        .continuous_in      (continuous_in),
        .counter_digits_in  (digits_a),
        .counter_carry_in   (carry_a),
        .counter_reset_out  (cre_a),
        .counter_enable_out (en_a),
        .gate_out           (gate_a),
        .busy_out           (busy_a),
        .disp               (bus_a)
    );

    freq_gate_controller #(.DIGITS_NUM(DB), .GATE_CYCLES(G)) dut_b (
        .clk_in             (clk),
        .reset_in           (reset_in),
        .signal_in          (signal_in),
        .start_in           (start_in),
        .continuous_in      (continuous_in),
        .counter_digits_in  (digits_b),
        .counter_carry_in   (carry_b),
        .counter_reset_out  (cre_b),
        .counter_enable_out (en_b),
        .gate_out           (gate_b),
        .busy_out           (busy_b),
        .disp               (bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Behavioural BCD counters attached to each DUT; carry is high while the
    // counter sits at its all-nines value.
    always @(posedge clk) begin
        if (cre_a) cnt_a <= 0;
        else if (en_a) cnt_a <= (cnt_a + 1) % MOD_A;
        if (cre_b) cnt_b <= 0;
        else if (en_b) cnt_b <= (cnt_b + 1) % MOD_B;
    end

    assign bcd_a    = to_bcd(cnt_a);
    assign bcd_b    = to_bcd(cnt_b);
    assign digits_a = bcd_a[4*DA-1:0];
    assign digits_b = bcd_b[4*DB-1:0];
    assign carry_a  = (cnt_a == MOD_A - 1);
    assign carry_b  = (cnt_b == MOD_B - 1);

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    // Reference model. A request sampled at edge E makes cycle E the clear
    // cycle, cycles E+1..E+G the window and E+G+1 the latch cycle; the result
    // is presented after edge E+G+2. A signal level first sampled at edge k
    // yields its count pulse in cycle k+2.
    always @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            measuring   = 1'b0;
            pulses      = 0;
            exp_valid   = 1'b0;
            exp_overrun = 1'b0;
            exp_busy    = 1'b0;
            exp_gate    = 1'b0;
            exp_creset  = 1'b1;
        end else begin
            edge_count++;
            m_latch = measuring && (edge_count == win_start + G + 2);
            if (measuring) begin
                m_phase = edge_count - 1 - win_start;
                if (m_phase >= 1 && m_phase <= G && h2 && !h3) pulses++;
            end
            h3 = h2; h2 = h1; h1 = signal_in;

            if (ack_in) begin
                exp_valid   = 1'b0;
                exp_overrun = 1'b0;
            end
            if (m_latch) begin
                if (exp_valid) exp_overrun = 1'b1;
                exp_valid = 1'b1;
                m_item.res = to_bcd(pulses % MOD_A);
                m_item.ovf = (pulses >= MOD_A);
                m_item.edge_at = edge_count;
                q_a.push_back(m_item);
                m_item.res = to_bcd(pulses % MOD_B);
                m_item.ovf = (pulses >= MOD_B);
                q_b.push_back(m_item);
            end

            if (m_latch) begin
                if (continuous_in) begin
                    win_start = edge_count;
                    pulses    = 0;
                end else begin
                    measuring = 1'b0;
                end
            end else if (!measuring && (start_in || continuous_in)) begin
                measuring = 1'b1;
                win_start = edge_count;
                pulses    = 0;
            end

            if (measuring) begin
                m_phase    = edge_count - win_start;
                exp_busy   = 1'b1;
                exp_gate   = (m_phase >= 1 && m_phase <= G);
                exp_creset = (m_phase == 0);
            end else begin
                exp_busy   = 1'b0;
                exp_gate   = 1'b0;
                exp_creset = 1'b1;
            end
        end
    end

    // Monitor for instance A: per-cycle status, plus a scoreboard pop one
    // cycle after the gate closes (that is when a new result is presented).
    bit    last_gate_a = 1'b0, pend_a = 1'b0;
    item_t got_a;
    always @(negedge clk) begin
        check_output("status_a", {busy_a, gate_a, cre_a, bus_a.result_valid_out, bus_a.result_overrun_out},
                     {exp_busy, exp_gate, exp_creset, exp_valid, exp_overrun});
        if (pend_a) begin
            pend_a = 1'b0;
            if (q_a.size() == 0) begin
                report_timeout("unexpected_result_a");
            end else begin
                got_a = q_a.pop_front();
                check_output("result_a", bus_a.result_out, got_a.res[4*DA-1:0]);
                check_output("overflow_a", bus_a.result_overflow_out, got_a.ovf);
                check_output("latch_edge_a", edge_count, got_a.edge_at);
            end
        end
        if (last_gate_a && !gate_a && reset_in) pend_a = 1'b1;
        last_gate_a = gate_a;
    end

    bit    last_gate_b = 1'b0, pend_b = 1'b0;
    item_t got_b;
    always @(negedge clk) begin
        if (pend_b) begin
            pend_b = 1'b0;
            if (q_b.size() == 0) begin
                report_timeout("unexpected_result_b");
            end else begin
                got_b = q_b.pop_front();
                check_output("result_b", bus_b.result_out, got_b.res[4*DB-1:0]);
                check_output("overflow_b", bus_b.result_overflow_out, got_b.ovf);
                check_output("valid_b", bus_b.result_valid_out, 1'b1);
            end
        end
        if (last_gate_b && !gate_b && reset_in) pend_b = 1'b1;
        last_gate_b = gate_b;
    end

    // Advances n cycles, driving the signal (and random controls) at negedges.
    task automatic apply_stimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (sig_mode)
                0: signal_in = sig_level;
                1: begin
                    signal_in = ((sig_phase % sig_period) < (sig_period / 2));
                    sig_phase++;
                end
                default: signal_in = 1'($urandom_range(0, 1));
            endcase
            if (rand_ctrl) begin
                start_in = ($urandom_range(0, 15) == 0);
                ack_in   = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 39) == 0) continuous_in = ~continuous_in;
            end
        end
    endtask

    // Returns at the negedge inside the latch cycle (gate just closed).
    task automatic wait_latch(input string name);
        bit ok;
        bit g;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            g = gate_a;
            apply_stimulus(1);
            if (g && !gate_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) report_timeout(name);
    endtask

    task automatic wait_gate_high(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            apply_stimulus(1);
            if (gate_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) report_timeout(name);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_counter_reset"}, cre_a, 1'b1);
        check_output({tag, "_enable"}, en_a, 1'b0);
        check_output({tag, "_gate"}, gate_a, 1'b0);
        check_output({tag, "_busy"}, busy_a, 1'b0);
        check_output({tag, "_result"}, bus_a.result_out, 8'h00);
        check_output({tag, "_overflow"}, bus_a.result_overflow_out, 1'b0);
        check_output({tag, "_valid"}, bus_a.result_valid_out, 1'b0);
        check_output({tag, "_overrun"}, bus_a.result_overrun_out, 1'b0);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        apply_stimulus(1);
        start_in = 1'b0;
    endtask

    task automatic pulse_ack();
        ack_in = 1'b1;
        apply_stimulus(1);
        ack_in = 1'b0;
    endtask

    initial begin
        $display("[TB] freq_gate_controller bench, GATE_CYCLES=%0d", G);
        #2 reset_in = 1'b0;
        #1 check_reset_values("por");
        apply_stimulus(3);
        reset_in = 1'b1;
        apply_stimulus(3);

        // continuous mode, period-2 signal, handshake corner cases
        sig_mode = 1; sig_period = 2; sig_phase = 0;
        continuous_in = 1'b1;
        wait_latch("latch1_timeout");
        apply_stimulus(1);
        check_output("cont_result_a", bus_a.result_out, 8'h10);
        check_output("cont_overflow_a", bus_a.result_overflow_out, 1'b0);
        check_output("ovf_result_b", bus_b.result_out, 4'h0);
        check_output("ovf_flag_b", bus_b.result_overflow_out, 1'b1);
        check_output("first_overrun", bus_a.result_overrun_out, 1'b0);
        wait_latch("latch2_timeout");
        apply_stimulus(1);
        check_output("second_latch_overrun", bus_a.result_overrun_out, 1'b1);
        check_output("second_latch_valid", bus_a.result_valid_out, 1'b1);
        wait_latch("latch3_timeout");
        pulse_ack();
        check_output("ack_with_latch_valid", bus_a.result_valid_out, 1'b1);
        check_output("ack_with_latch_overrun", bus_a.result_overrun_out, 1'b0);
        apply_stimulus(3);
        pulse_ack();
        check_output("ack_alone_valid", bus_a.result_valid_out, 1'b0);
        check_output("ack_alone_overrun", bus_a.result_overrun_out, 1'b0);
        apply_stimulus(5);
        continuous_in = 1'b0;
        wait_latch("latch4_timeout");
        apply_stimulus(2);
        check_output("drop_cont_busy", busy_a, 1'b0);
        check_output("drop_cont_result", bus_a.result_out, 8'h10);
        pulse_ack();

        // single shot, period-4 signal; result left unacknowledged
        sig_period = 4; sig_phase = 0;
        apply_stimulus(4);
        pulse_start();
        wait_latch("single_timeout");
        apply_stimulus(1);
        check_output("single_result", bus_a.result_out, 8'h05);
        check_output("single_busy", busy_a, 1'b0);
        apply_stimulus(10);
        check_output("single_stays_idle", busy_a, 1'b0);

        // asynchronous reset in the middle of a gate window
        sig_period = 2; sig_phase = 0;
        pulse_start();
        wait_gate_high("gate_high_timeout");
        apply_stimulus(5);
        #3 reset_in = 1'b0;
        #1 check_reset_values("midgate");
        apply_stimulus(2);
        reset_in = 1'b1;
        apply_stimulus(G + 10);
        check_output("post_reset_valid", bus_a.result_valid_out, 1'b0);

        // constant signal, start pulsed again during the window
        sig_mode = 0; sig_level = 1'b0;
        apply_stimulus(4);
        pulse_start();
        apply_stimulus(6);
        pulse_start();
        wait_latch("const_timeout");
        apply_stimulus(1);
        check_output("const_result", bus_a.result_out, 8'h00);
        apply_stimulus(G + 5);
        check_output("no_extra_measurement", busy_a, 1'b0);
        pulse_ack();

        // randomised signal and controls against the model
        sig_mode = 2;
        rand_ctrl = 1'b1;
        apply_stimulus(600);
        rand_ctrl = 1'b0;
        start_in = 1'b0;
        continuous_in = 1'b0;
        ack_in = 1'b0;
        apply_stimulus(G + 10);
        pulse_ack();
        apply_stimulus(2);
        check_output("queue_drained_a", q_a.size(), 0);
        check_output("queue_drained_b", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
